// File: rtl/morse_pkg.sv
// morse_pkg
// Shared definitions for the Morse key encoder: the two symbol codes that
// get packed into a letter, and the state type of the press/gap FSM.
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_e;

endpackage

// File: rtl/morse_key_encoder_sync_2ff.sv
// sync_2ff
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Both flops clear on reset, so the synchronised level always starts low.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   d_i    in  asynchronous input level
//   q_o    out synchronised level, two cycles behind d_i
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/morse_key_encoder.sv
// morse_key_encoder
// Times presses of a single Morse key, classifies each as dot or dash,
// packs up to MAX_SYMBOLS symbols into a left-shifted letter code and
// hands completed letters to a downstream stage over valid/ready.
// Ports:
//   clk           in  system clock
//   rst_n         in  asynchronous active-low reset
//   key           in  raw key level, 1 = pressed
//   flush         in  single-cycle request to commit the current letter
//   letter_ready  in  downstream accepts the presented letter
//   letter        out letter code, newest symbol in the LSBs
//   sym_count     out number of symbols in letter
//   letter_err    out letter had more than MAX_SYMBOLS symbols
//   letter_valid  out output register holds a letter
//   overrun       out one-cycle pulse when a commit was dropped
//   key_active    out synchronised key level
module morse_key_encoder
  import morse_pkg::*;
#(
  parameter int DOT_MIN     = 2,
  parameter int DASH_MIN    = 6,
  parameter int LETTER_GAP  = 10,
  parameter int MAX_SYMBOLS = 5,
  parameter int CNT_W       = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               key,
  input  logic                               flush,
  input  logic                               letter_ready,
  output logic [2*MAX_SYMBOLS-1:0]           letter,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]   sym_count,
  output logic                               letter_err,
  output logic                               letter_valid,
  output logic                               overrun,
  output logic                               key_active
);

  localparam int LW  = 2 * MAX_SYMBOLS;
  localparam int SCW = $clog2(MAX_SYMBOLS + 1);

  localparam logic [CNT_W-1:0] DOT_MIN_C  = CNT_W'(DOT_MIN);
  localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(LETTER_GAP);
  localparam logic [SCW-1:0]   MAX_SYM_C  = SCW'(MAX_SYMBOLS);

  logic key_s;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] press_q, press_d;
  logic [CNT_W-1:0] gap_q,   gap_d;
  logic [LW-1:0]    acc_q,   acc_d;
  logic [SCW-1:0]   cnt_q,   cnt_d;
  logic             err_q,   err_d;
  logic             commit;

  logic [LW-1:0]    letter_q,  letter_d;
  logic [SCW-1:0]   symcnt_q,  symcnt_d;
  logic             lerr_q,    lerr_d;
  logic             valid_q,   valid_d;
  logic             overrun_q, overrun_d;
  logic             load;

  logic [1:0]       code;

  sync_2ff u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (key),
    .q_o   (key_s)
  );

  // Saturation at DASH_MIN means anything at or above it reads as a dash.
  assign code = (press_q >= DASH_MIN_C) ? SYM_DASH : SYM_DOT;

  always_comb begin
    state_d = state_q;
    press_d = press_q;
    gap_d   = gap_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    commit  = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        if (flush && (cnt_q != '0)) begin
          commit = 1'b1;
        end
        // A new press takes priority over a gap timeout in the same cycle,
        // so the letter keeps growing instead of being committed.
        if (key_s) begin
          state_d = PRESS;
          press_d = CNT_W'(1);
          gap_d   = '0;
        end else if (state_q == GAP) begin
          if (commit || (gap_q == GAP_C)) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + CNT_W'(1);
          end
        end
      end

      PRESS: begin
        if (key_s) begin
          if (press_q < DASH_MIN_C) begin
            press_d = press_q + CNT_W'(1);
          end
        end else if (press_q < DOT_MIN_C) begin
          state_d = (cnt_q != '0) ? GAP : IDLE;
        end else if (cnt_q == MAX_SYM_C) begin
          err_d   = 1'b1;
          state_d = GAP;
        end else begin
          acc_d   = (acc_q << 2) | LW'(code);
          cnt_d   = cnt_q + SCW'(1);
          state_d = GAP;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (commit) begin
      acc_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      press_q <= '0;
      gap_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      gap_q   <= gap_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // A commit may load the output register in the same cycle the previous
  // letter is being accepted; otherwise an occupied register drops it.
  always_comb begin
    letter_d  = letter_q;
    symcnt_d  = symcnt_q;
    lerr_d    = lerr_q;
    valid_d   = valid_q;
    load      = commit && (!valid_q || letter_ready);
    overrun_d = commit && !load;

    if (load) begin
      letter_d = acc_q;
      symcnt_d = cnt_q;
      lerr_d   = err_q;
      valid_d  = 1'b1;
    end else if (valid_q && letter_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      letter_q  <= '0;
      symcnt_q  <= '0;
      lerr_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      letter_q  <= letter_d;
      symcnt_q  <= symcnt_d;
      lerr_q    <= lerr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign letter       = letter_q;
  assign sym_count    = symcnt_q;
  assign letter_err   = lerr_q;
  assign letter_valid = valid_q;
  assign overrun      = overrun_q;
  assign key_active   = key_s;

endmodule
